uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- UART serial receiver; the consumer end of the baud-rate tick.
- Samples the `rx` line on an oversample tick, typically the baud generator's `out` configured for OVERSAMPLE ticks per bit.
- Recovers 8N1 frames (LSB first) and presents each byte on a valid/ack handshake with frame-error and overrun status.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, tick pulses per bit period (even, >=4).

Ports:
- clk  input  1  system clock, all logic on posedge.
- areset_n  input  1  asynchronous active-low reset.
- tick  input  1  oversample strobe, one clk wide; counting advances only when high.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  received byte, bit 0 = first data bit.
- rx_valid  output  1  rx_data holds an unconsumed byte (level).
- rx_ack  input  1  consumer takes the byte; effective only while rx_valid=1.
- frame_err  output  1  stop bit of the held byte sampled 0.
- overrun  output  1  sticky: a completed frame was dropped because rx_valid was still high.
- parity_err  output  1  see Optional Feature.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (areset_n=0, immediate, any state):
  - FSM goes to IDLE; counters cleared.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
  - Both synchronizer flops = 1.
- Input synchronizer: 2-flop on rx. rx_s is the second flop's output; latency is 2 clk.
- Counters:
  - tcnt, width clog2(OVERSAMPLE): increments on tick; cleared on every state change.
  - bcnt: counts data bits.
- IDLE:
  - rx_s=0 seen on a clk edge -> START with tcnt=0. This does not wait for tick.
- START:
  - On the tick where tcnt==OVERSAMPLE/2-1 (bit centre), sample rx_s.
  - rx_s=0 -> DATA, tcnt=0, bcnt=0.
  - rx_s=1 -> IDLE. This is glitch rejection: no outputs change.
- DATA:
  - On the tick where tcnt==OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift) and increment bcnt.
  - After the DATA_BITS-th sample -> STOP, or -> PARITY when PARITY_EN is defined.
- STOP:
  - On the tick where tcnt==OVERSAMPLE-1, sample the stop bit and complete the frame; next state IDLE.
  - Because completion is at the stop-bit centre, a new start edge is detectable from the next clk.
- Frame completion, case rx_valid=0, or rx_valid=1 with rx_ack=1 in the same cycle:
  - rx_data <= shift register; rx_valid <= 1.
  - frame_err <= ~stop_sample; parity_err updated.
  - The data is delivered even when frame_err=1.
- Frame completion, case rx_valid=1 and rx_ack=0:
  - Frame discarded; rx_data, frame_err and parity_err unchanged.
  - overrun <= 1.
- rx_ack with rx_valid=1 and no completion that cycle:
  - rx_valid <= 0; overrun <= 0.
  - rx_data is held and frame_err is held.
  - rx_ack while rx_valid=0 is ignored.
- Output timing:
  - All outputs are registered.
  - rx_valid rises the clk after the stop-sample tick.
- tick held permanently high is legal: each bit is then OVERSAMPLE clks.
- rx change mid-frame is not re-checked except at the sample points.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Extra parameter PARITY_ODD (default 0 = even parity).
  - Extra state PARITY between DATA and STOP. It samples at tcnt==OVERSAMPLE-1 and computes the expected parity as XOR of the data bits, XOR PARITY_ODD.
  - parity_err is loaded with (sample != expected) at frame completion, following the same delivery/drop rules as frame_err.
- Undefined:
  - No PARITY state; frame is start + DATA_BITS + stop.
  - parity_err is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- tick=1 every clk, OVERSAMPLE=16: send 0xA5 (8N1, 16 clk/bit), never ack.
  - Required: rx_valid=1, rx_data=8'hA5, frame_err=0, overrun=0.
  - Required: rx_valid rises 2 clk (sync) + 8 + 16*9 clk after the rx falling edge.
- Same timing, stop bit driven 0, data 0x3C.
  - Required: rx_valid=1, rx_data=8'h3C, frame_err=1.
  - Next frame 0x01 with valid stop, after ack: frame_err=0.
- rx low pulse of 4 clks in IDLE.
  - Required: busy pulses, FSM returns to IDLE, rx_valid stays 0, no outputs change.
- Back-to-back frames 0x11 then 0x22, no ack.
  - Required: rx_data stays 8'h11, overrun=1.
  - Then rx_ack=1 for 1 clk: rx_valid=0, overrun=0.
- Back-to-back frames with rx_ack asserted exactly in the completion cycle of frame 2.
  - Required: rx_data=8'h22, rx_valid stays 1, overrun=0.
- tick every 4th clk; assert areset_n=0 mid-DATA of frame 0x55, then release and send 0x0F.
  - Required: all outputs 0 during reset, then rx_data=8'h0F, rx_valid=1.
  - With UART_RX_PARITY_EN and PARITY_ODD=0, a wrong parity bit gives parity_err=1.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1-style UART receiver running off an oversample tick.
// A 2-flop synchronizer feeds an IDLE/START/DATA/STOP FSM. Each completed byte
// is presented on a level rx_valid / rx_ack handshake, together with
// frame-error and sticky overrun status.
// Optional parity stage: define UART_RX_PARITY_EN to add a PARITY state and a
// PARITY_ODD parameter. Without the macro, parity_err is tied low. The port
// list is the same in both builds.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
`ifdef UART_RX_PARITY_EN
    parameter logic PARITY_ODD = 1'b0,
`endif
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 complete;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q, overrun_q, busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 parity_err_q;
`endif

    // Two-flop synchronizer on the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            // NOTE: non-blocking (<=) makes both stages sample their pre-edge
            // values; blocking here would collapse the chain into one flop.
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Next-state logic: bit timing, sample points and the data shift register.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        tcnt_d   = tick ? tcnt_q + TW'(1) : tcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        complete = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                // A falling edge starts the frame without waiting for tick.
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (tick && tcnt_q == TC_HALF) begin
                    tcnt_d = '0;
                    bcnt_d = '0;
                    // Start bit still low at its centre: real frame, else glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && tcnt_q == TC_LAST) begin
                    tcnt_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + BW'(1);
                    if (bcnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick && tcnt_q == TC_LAST) begin
                    tcnt_d    = '0;
                    par_bit_d = rx_s;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Completing at the stop-bit centre leaves half a bit to catch
                // the next start edge.
                if (tick && tcnt_q == TC_LAST) begin
                    tcnt_d   = '0;
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                tcnt_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            // NOTE: the shift register is reset as well, so no X can ever
            // propagate into rx_data or the parity calculation.
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // Output registers: deliver or drop on completion, and the consumer handshake.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            busy_q <= (state_d != S_IDLE);
            if (complete) begin
                if (!rx_valid_q || rx_ack) begin
                    // A frame with a bad stop bit is still delivered, flagged.
                    rx_data_q   <= shift_q;
                    rx_valid_q  <= 1'b1;
                    frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= (par_bit_q != ((^shift_q) ^ PARITY_ODD));
`endif
                end else begin
                    // The held byte was never consumed: drop the new one.
                    overrun_q <= 1'b1;
                end
            end else if (rx_ack && rx_valid_q) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
